// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU with registered result/flags and an iterated LFSR op.
// Ports: Clk/Reset; InValid/InReady/OP/InputA/InputB/Count in; OutValid/OutReady/Out/Zero/Negative/Carry out.
module seq_alu #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       OP,
  input  logic [W-1:0]     InputA,
  input  logic [W-1:0]     InputB,
  input  logic [CNT_W-1:0] Count,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [W-1:0]     Out,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry
);

  localparam int SW = W - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_LSL = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_PAS = 4'd7;
  localparam logic [3:0] OP_PAR = 4'd8;
  localparam logic [3:0] OP_LFS = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]    lfsr_q;
  logic [SW-1:0]    taps_q;
  logic [CNT_W-1:0] rem_q;

  function automatic logic [SW-1:0] lfsr_step(
    input logic [SW-1:0] s,
    input logic [SW-1:0] t
  );
    return {s[SW-2:0], ^(t & s)};
  endfunction

  logic          accept;
  logic          lfsr_long;
  logic          last;
  logic [SW-1:0] first_step;
  logic [SW-1:0] run_step;
  logic [W:0]    sum;
  logic [W:0]    diff;
  logic [W-1:0]  alu_out;
  logic          alu_carry;
  logic [W-1:0]  res_d;
  logic          cy_d;
  logic          load;

  assign InReady    = (state_q == IDLE) && !Reset;
  assign OutValid   = (state_q == DONE);
  assign accept     = InValid && InReady;
  assign lfsr_long  = (OP == OP_LFS) && (Count > CNT_W'(1));
  assign last       = (rem_q == CNT_W'(1));
  assign first_step = lfsr_step(InputB[SW-1:0], InputA[SW-1:0]);
  assign run_step   = lfsr_step(lfsr_q, taps_q);
  assign sum        = {1'b0, InputA} + {1'b0, InputB};
  assign diff       = {1'b0, InputA} - {1'b0, InputB};

  // Shift amounts of W or more fall out naturally as zero.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (OP)
      OP_ADD: begin
        alu_out   = sum[W-1:0];
        alu_carry = sum[W];
      end
      OP_SUB, OP_CMP: begin
        alu_out   = diff[W-1:0];
        alu_carry = diff[W];
      end
      OP_XOR: alu_out = InputA ^ InputB;
      OP_AND: alu_out = InputA & InputB;
      OP_LSL: alu_out = InputA << InputB;
      OP_LSR: alu_out = InputA >> InputB;
      OP_PAS: alu_out = InputB;
      OP_PAR: alu_out = {^InputB[SW-1:0], InputB[SW-1:0]};
      OP_LFS: alu_out = {1'b0, first_step};
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_d   = alu_out;
    cy_d    = alu_carry;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (lfsr_long) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            load    = 1'b1;
          end
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
          load    = 1'b1;
          res_d   = {1'b0, run_step};
          cy_d    = 1'b0;
        end
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      Out      <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      lfsr_q   <= '0;
      taps_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        Out      <= res_d;
        Zero     <= (res_d == '0);
        Negative <= res_d[W-1];
        Carry    <= cy_d;
      end
      if ((state_q == IDLE) && accept && lfsr_long) begin
        lfsr_q <= first_step;
        taps_q <= InputA[SW-1:0];
        rem_q  <= Count - CNT_W'(1);
      end else if (state_q == RUN) begin
        lfsr_q <= run_step;
        rem_q  <= rem_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed plus random checks of seq_alu against an arithmetic reference model.
// Drives on falling edges, samples on falling edges.
module tb_seq_alu;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       InValid;
  logic       InReady;
  logic [3:0] OP;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic [3:0] Count;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] Out;
  logic       Zero;
  logic       Negative;
  logic       Carry;

  int tests = 0;
  int fails = 0;

  seq_alu #(.W(8), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .OP(OP), .InputA(InputA), .InputB(InputB), .Count(Count),
    .OutValid(OutValid), .OutReady(OutReady),
    .Out(Out), .Zero(Zero), .Negative(Negative), .Carry(Carry)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int op, input int a, input int b, input int c,
                       output int o, output int cy, output int lat);
    int s, n;
    o = 0; cy = 0; lat = 1;
    case (op)
      0: begin o = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
      1, 6: begin o = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
      2: o = a ^ b;
      3: o = a & b;
      4: o = (b >= 8) ? 0 : (a * (1 << b)) % 256;
      5: o = (b >= 8) ? 0 : a / (1 << b);
      7: o = b;
      8: o = (b % 128) + 128 * ($countones(b % 128) % 2);
      9: begin
        n = (c == 0) ? 1 : c;
        s = b % 128;
        for (int k = 0; k < n; k++)
          s = (s * 2) % 128 + ($countones((a % 128) & s) % 2);
        o = s;
        lat = n;
      end
      default: o = 0;
    endcase
  endtask

  task automatic run_op(input int op, input int a, input int b, input int c);
    int eo, ecy, elat, lat;
    model(op, a, b, c, eo, ecy, elat);
    @(negedge Clk);
    OP = 4'(op); InputA = 8'(a); InputB = 8'(b); Count = 4'(c);
    InValid = 1'b1;
    #1 check("in_ready", InReady, 1);
    @(negedge Clk);
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    check("out_valid", OutValid, 1);
    check("latency", lat, elat);
    check("out", Out, eo);
    check("zero", Zero, (eo == 0) ? 1 : 0);
    check("neg", Negative, eo / 128);
    check("carry", Carry, ecy);
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    check("drain", OutValid, 0);
  endtask

  initial begin
    int op, a, b, c;
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    OP = '0; InputA = '0; InputB = '0; Count = '0;
    repeat (2) @(negedge Clk);
    check("rst_out", Out, 0);
    check("rst_flags", {Zero, Negative, Carry}, 0);
    check("rst_ovalid", OutValid, 0);
    check("rst_iready", InReady, 0);
    Reset = 1'b0;
    #1 check("post_rst_iready", InReady, 1);

    run_op(0, 8'hF0, 8'h20, 0);
    check("plan_add", {Out, Zero, Negative, Carry}, {8'h10, 3'b001});
    run_op(6, 8'h03, 8'h05, 0);
    check("plan_cmp", {Out, Zero, Negative, Carry}, {8'hFE, 3'b011});
    run_op(1, 8'h05, 8'h05, 0);
    check("plan_sub", {Out, Zero, Negative, Carry}, {8'h00, 3'b100});
    run_op(9, 8'h60, 8'h41, 2);
    check("plan_lfsr2", Out, 8'h06);
    run_op(9, 8'h60, 8'h41, 0);
    check("plan_lfsr0", Out, 8'h03);
    run_op(8, 8'h00, 8'h07, 0);
    check("plan_par", {Out, Negative}, {8'h87, 1'b1});
    run_op(4, 8'h81, 8'h09, 0);
    check("plan_lsl", {Out, Zero}, {8'h00, 1'b1});
    run_op(5, 8'h80, 8'h07, 0);
    run_op(5, 8'hFF, 8'h08, 0);
    run_op(12, 8'hFF, 8'hFF, 0);
    run_op(9, 8'h7F, 8'h7F, 15);
    run_op(9, 8'h5A, 8'h33, 1);

    // backpressure with a competing request
    @(negedge Clk);
    OP = 4'd0; InputA = 8'hF0; InputB = 8'h20; Count = 4'd0;
    InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    check("bp_valid", OutValid, 1);
    OP = 4'd2; InputA = 8'hFF; InputB = 8'h0F; InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("bp_hold", {OutValid, InReady, Out, Carry}, {2'b10, 8'h10, 1'b1});
    end
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    check("bp_release", {OutValid, InReady}, 2'b01);
    @(negedge Clk);
    InValid = 1'b0;
    check("bp_new", {OutValid, Out, Carry}, {1'b1, 8'hF0, 1'b0});
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;

    // abort a long LFSR run with reset
    run_op(7, 8'h00, 8'h5A, 0);
    @(negedge Clk);
    OP = 4'd9; InputA = 8'h60; InputB = 8'h41; Count = 4'd15;
    InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_run", {OutValid, InReady}, 2'b00);
      @(negedge Clk);
    end
    Reset = 1'b1;
    #1 check("abort_rst_iready", InReady, 0);
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_out", {OutValid, Out, Zero, Negative, Carry}, 0);
    #1 check("abort_iready", InReady, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("abort_quiet", OutValid, 0);
    end

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      c  = $urandom_range(0, 15);
      if (op == 4 || op == 5) b = $urandom_range(0, 10);
      run_op(op, a, b, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
